mag_compare_seq: RTL

//  Sequential magnitude comparator sitting directly downstream of the 2-bit comparator (e/g/l outputs).

---
 rtl/mag_cmp_pkg.sv | 14 +
 rtl/mag_compare_seq_if.sv | 30 +++
 rtl/mag_flag_check.sv | 12 +
 rtl/mag_compare_seq.sv | 127 ++++++++++++
 4 files changed

// File: rtl/mag_cmp_pkg.sv
// rtl/mag_cmp_pkg.sv - shared state type and constants for the sequential magnitude comparator
package mag_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DIGIT_W     = 2;
    localparam int MIN_NDIGITS = 2;
    localparam int MAX_NDIGITS = 16;

endpackage

// File: rtl/mag_compare_seq_if.sv
// rtl/mag_compare_seq_if.sv - handshake, digit request and result bundle for mag_compare_seq
interface mag_compare_seq_if #(
    parameter int NDIGITS = 4
);
    localparam int IDX_W = $clog2(NDIGITS);

    logic             start;
    logic             digit_valid;
    logic             e_in;
    logic             g_in;
    logic             l_in;
    logic [IDX_W-1:0] digit_idx;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic             err;

    modport master (
        output start, digit_valid, e_in, g_in, l_in,
        input  digit_idx, busy, done, eq, gt, lt, err
    );

    modport slave (
        input  start, digit_valid, e_in, g_in, l_in,
        output digit_idx, busy, done, eq, gt, lt, err
    );

endinterface

// File: rtl/mag_flag_check.sv
// rtl/mag_flag_check.sv - flags a 2-bit comparator e/g/l triple as legal only when exactly one is high
module mag_flag_check (
    input  logic i_e,
    input  logic i_g,
    input  logic i_l,
    output logic o_legal
);

    // Odd parity rules out 0 or 2 set; the AND term rules out all 3 set.
    assign o_legal = (i_e ^ i_g ^ i_l) & ~(i_e & i_g & i_l);

endmodule

// File: rtl/mag_compare_seq.sv
// rtl/mag_compare_seq.sv - MSB-first sequential magnitude comparator; EARLY_EXIT_EN stops at first differing digit
module mag_compare_seq
    import mag_cmp_pkg::*;
#(
    parameter int NDIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mag_compare_seq_if.slave      bus
);

    localparam int IDX_W = $clog2(NDIGITS);
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIGITS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_eq;
    logic             r_gt;
    logic             r_lt;
    logic             r_err;
    logic             r_decided;

    logic w_legal;
    logic w_consume;
    logic w_last;
    logic w_dec_g;
    logic w_dec_l;
    logic w_exit;
    logic w_busy;
    logic w_done;

    mag_flag_check u_flag_check (
        .i_e     (bus.e_in),
        .i_g     (bus.g_in),
        .i_l     (bus.l_in),
        .o_legal (w_legal)
    );

    assign w_consume = (r_state == RUN) && bus.digit_valid;
    assign w_last    = (r_idx == '0);
    assign w_dec_g   = w_legal && bus.g_in && !r_decided;
    assign w_dec_l   = w_legal && bus.l_in && !r_decided;

`ifdef EARLY_EXIT_EN
    assign w_exit = w_consume && (w_dec_g || w_dec_l);
`else
    assign w_exit = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_consume && (w_last || w_exit)) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_eq      <= 1'b0;
            r_gt      <= 1'b0;
            r_lt      <= 1'b0;
            r_err     <= 1'b0;
            r_decided <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == IDLE) && bus.start) begin
                r_idx     <= IDX_TOP;
                r_eq      <= 1'b0;
                r_gt      <= 1'b0;
                r_lt      <= 1'b0;
                r_err     <= 1'b0;
                r_decided <= 1'b0;
            end else if (w_consume) begin
                if (!w_legal) begin
                    r_err <= 1'b1;
                end
                if (w_dec_g) begin
                    r_gt      <= 1'b1;
                    r_decided <= 1'b1;
                end
                if (w_dec_l) begin
                    r_lt      <= 1'b1;
                    r_decided <= 1'b1;
                end
                // Equality can only be concluded once the least significant digit matched too.
                if (w_last) begin
                    if (!r_decided && !w_dec_g && !w_dec_l) begin
                        r_eq <= 1'b1;
                    end
                end else begin
                    r_idx <= r_idx - IDX_W'(1);
                end
            end
        end
    end

    assign bus.digit_idx = r_idx;
    assign bus.busy      = w_busy;
    assign bus.done      = w_done;
    assign bus.eq        = r_eq;
    assign bus.gt        = r_gt;
    assign bus.lt        = r_lt;
    assign bus.err       = r_err;

endmodule
